// File: rtl/ws2812_stream_sender_if.sv
// Pixel stream handshake for ws2812_stream_sender: colour word plus valid/ready.
interface ws2812_stream_sender_if #(
  parameter int BITS_PER_LED = 24
) ();
  logic [BITS_PER_LED-1:0] pix_data;
  logic                    pix_valid;
  logic                    pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/ws2812_stream_sender.sv
// WS2812B/SK6812 frame sender: streams NUM_LEDS colour words MSB-first as NZR bits, then latch low time.
// Optional per-byte brightness scaling on pixel load when WS2812_BRIGHTNESS_EN is defined.
//
// state | meaning
// IDLE  | line low, Ready2Go high, waiting for Go
// FETCH | pix_ready high, waiting for next colour word (stall timeout after the first LED)
// BIT   | shifting one bit period out on dataOut
// LATCH | line low for RESET_CYC cycles, then done pulse
module ws2812_stream_sender #(
  parameter int NUM_LEDS     = 5,
  parameter int BITS_PER_LED = 24,
  parameter int T0H_CYC      = 20,
  parameter int T1H_CYC      = 40,
  parameter int BIT_CYC      = 62,
  parameter int RESET_CYC    = 15000,
  parameter int STALL_CYC    = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic Go,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  ws2812_stream_sender_if.slave pix,
  output logic dataOut,
  output logic Ready2Go,
  output logic done,
  output logic underrun
);

  localparam int CW = $clog2(BIT_CYC + 1);
  localparam int BW = $clog2(BITS_PER_LED);
  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam int SW = $clog2(STALL_CYC + 1);
  localparam int RW = $clog2(RESET_CYC + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] T0H_V      = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_V      = CW'(T1H_CYC);
  localparam logic [BW-1:0] BIT_TOP    = BW'(BITS_PER_LED - 1);
  localparam logic [LW-1:0] LED_LAST   = LW'(NUM_LEDS - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYC - 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYC - 1);

  typedef enum logic [1:0] {IDLE, FETCH, BIT, LATCH} state_t;

  state_t                  state;
  logic [BITS_PER_LED-1:0] shreg;
  logic [BITS_PER_LED-1:0] load_word;
  logic [BW-1:0]           bit_cnt;
  logic [CW-1:0]           cyc_cnt;
  logic [CW-1:0]           cyc_nxt;
  logic [CW-1:0]           thr;
  logic [LW-1:0]           led_cnt;
  logic [SW-1:0]           stall_cnt;
  logic [RW-1:0]           lat_cnt;

  assign pix.pix_ready = (state == FETCH);
  assign cyc_nxt       = cyc_cnt + CW'(1);
  assign thr           = shreg[BITS_PER_LED-1] ? T1H_V : T0H_V;

`ifdef WS2812_BRIGHTNESS_EN
  always_comb begin
    load_word = pix.pix_data;
    for (int i = 0; i < BITS_PER_LED / 8; i++) begin
      load_word[i*8 +: 8] = 8'(({8'd0, pix.pix_data[i*8 +: 8]} * ({8'd0, brightness} + 16'd1)) >> 8);
    end
  end
`else
  assign load_word = pix.pix_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      cyc_cnt   <= '0;
      led_cnt   <= '0;
      stall_cnt <= '0;
      lat_cnt   <= '0;
      dataOut   <= 1'b0;
      Ready2Go  <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dataOut  <= 1'b0;
          Ready2Go <= 1'b1;
          if (Go) begin
            state     <= FETCH;
            underrun  <= 1'b0;
            led_cnt   <= '0;
            stall_cnt <= '0;
            Ready2Go  <= 1'b0;
          end
        end
        FETCH: begin
          if (pix.pix_valid) begin
            shreg   <= load_word;
            bit_cnt <= BIT_TOP;
            cyc_cnt <= '0;
            dataOut <= 1'b1;  // every bit starts high since T0H_CYC > 0
            state   <= BIT;
          end else if (led_cnt != '0) begin
            if (stall_cnt == STALL_LAST) begin
              underrun <= 1'b1;
              lat_cnt  <= RST_LAST;
              state    <= LATCH;
            end else begin
              stall_cnt <= stall_cnt + SW'(1);
            end
          end
        end
        BIT: begin
          if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt != '0) begin
              shreg   <= {shreg[BITS_PER_LED-2:0], 1'b0};
              bit_cnt <= bit_cnt - BW'(1);
              dataOut <= 1'b1;
            end else begin
              dataOut <= 1'b0;
              led_cnt <= led_cnt + LW'(1);
              if (led_cnt == LED_LAST) begin
                lat_cnt <= RST_LAST;
                state   <= LATCH;
              end else begin
                stall_cnt <= '0;
                state     <= FETCH;
              end
            end
          end else begin
            cyc_cnt <= cyc_nxt;
            dataOut <= (cyc_nxt < thr);
          end
        end
        LATCH: begin
          dataOut <= 1'b0;
          if (lat_cnt == '0) begin
            done     <= 1'b1;
            Ready2Go <= 1'b1;
            state    <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_stream_sender.sv
// Bench for ws2812_stream_sender: bit-width scoreboard on the main instance, directed RGBW instance.
module tb_ws2812_stream_sender;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic go = 1'b0, dout, r2g, done, und;
  logic go2 = 1'b0, dout2, r2g2, done2, und2;
  logic [7:0] bright = 8'd255;
  logic [7:0] bright2 = 8'd255;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0;
  bit exp_q[$];
  int rise_q[$];
  int hi_len = 0;
  logic prev = 1'b0;

  ws2812_stream_sender_if #(.BITS_PER_LED(24)) pif ();
  ws2812_stream_sender_if #(.BITS_PER_LED(32)) pif2 ();

  ws2812_stream_sender #(
    .NUM_LEDS(2), .BITS_PER_LED(24), .T0H_CYC(3), .T1H_CYC(7),
    .BIT_CYC(10), .RESET_CYC(50), .STALL_CYC(20)
  ) dut (
    .clk(clk), .reset(reset), .Go(go),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .pix(pif.slave), .dataOut(dout), .Ready2Go(r2g), .done(done), .underrun(und)
  );

  ws2812_stream_sender #(
    .NUM_LEDS(1), .BITS_PER_LED(32), .T0H_CYC(3), .T1H_CYC(7),
    .BIT_CYC(10), .RESET_CYC(50), .STALL_CYC(20)
  ) dut_rgbw (
    .clk(clk), .reset(reset), .Go(go2),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness(bright2),
`endif
    .pix(pif2.slave), .dataOut(dout2), .Ready2Go(r2g2), .done(done2), .underrun(und2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode every high pulse of the main line and compare it with the next queued bit.
  always @(negedge clk) begin
    if (!reset) begin
      hi_len = 0;
      prev = 1'b0;
      exp_q.delete();
    end else begin
      if (dout) begin
        if (!prev) rise_q.push_back(cyc);
        hi_len++;
      end else if (prev) begin
        if (exp_q.size() == 0) check("unexpected_pulse", hi_len, 0);
        else check("bit_high_width", hi_len, exp_q.pop_front() ? 7 : 3);
        hi_len = 0;
      end
      prev = dout;
    end
  end

  task automatic start_frame();
    rise_q.delete();
    @(negedge clk);
    check("ready2go_before_go", r2g, 1'b1);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("ready2go_drop", r2g, 1'b0);
    check("pix_ready_in_fetch", pif.pix_ready, 1'b1);
  endtask

  task automatic send_pix(input logic [23:0] d, input logic [23:0] e, input int hold,
                          input bit expect_acc, output int f_cyc, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (!pif.pix_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pix_ready_wait", (n < 500), 1'b1);
    f_cyc = cyc;
    repeat (hold) @(negedge clk);
    pif.pix_data = d;
    pif.pix_valid = 1'b1;
    if (expect_acc) for (int i = 23; i >= 0; i--) exp_q.push_back(e[i]);
    @(posedge clk); #1;
    acc_cyc = cyc;
    pif.pix_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", (n < 3000), 1'b1);
    dc = cyc;
    check("ready2go_at_done", r2g, 1'b1);
    check("dataout_low_at_done", dout, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, a, a0, dc, n, hi;
    logic [31:0] w32;
    pif.pix_data = '0;
    pif.pix_valid = 1'b0;
    pif2.pix_data = '0;
    pif2.pix_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_dataout", dout, 1'b0);
    check("rst_ready2go", r2g, 1'b0);
    check("rst_pix_ready", pif.pix_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_underrun", und, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready2go_after_release", r2g, 1'b1);

    // nominal timing: 0xFF0000 then 0x00000F, always valid
    start_frame();
    send_pix(24'hFF0000, 24'hFF0000, 0, 1, f, a0);
    send_pix(24'h00000F, 24'h00000F, 0, 1, f, a);
    wait_done(dc);
    check("t1_pulse_count", rise_q.size(), 48);
    check("t1_first_latency", rise_q[0], a0);
    check("t1_bit_period", rise_q[1] - rise_q[0], 10);
    check("t1_led_gap", rise_q[24] - rise_q[23], 11);
    check("t1_done_delay", dc - rise_q[47], 60);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_underrun", und, 1'b0);

    // handshake stall of 10 cycles before LED 1
    start_frame();
    send_pix(24'h5A0FF0, 24'h5A0FF0, 0, 1, f, a);
    send_pix(24'h0F00F1, 24'h0F00F1, 10, 1, f, a);
    wait_done(dc);
    check("t2_pulse_count", rise_q.size(), 48);
    check("t2_stall_gap", rise_q[24] - rise_q[23], 21);
    check("t2_underrun", und, 1'b0);
    check("t2_queue_empty", exp_q.size(), 0);

    // underrun: 25 cycles without a pixel before LED 1
    start_frame();
    send_pix(24'hC3C3C3, 24'hC3C3C3, 0, 1, f, a);
    send_pix(24'h111111, 24'h111111, 25, 0, f, a);
    wait_done(dc);
    check("t3_abort_done_delay", dc - f, 70);
    check("t3_underrun_set", und, 1'b1);
    check("t3_pulse_count", rise_q.size(), 24);
    check("t3_queue_empty", exp_q.size(), 0);

    // next Go clears underrun; then reset mid-bit
    start_frame();
    check("t4_underrun_cleared", und, 1'b0);
    send_pix(24'hA5A5A5, 24'hA5A5A5, 0, 1, f, a);
    n = 0;
    @(negedge clk);
    while (!dout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_high_wait", (n < 100), 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t4_reset_dataout", dout, 1'b0);
    check("t4_reset_ready2go", r2g, 1'b0);
    check("t4_reset_pix_ready", pif.pix_ready, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t4_ready2go_after", r2g, 1'b1);
    check("t4_underrun_after", und, 1'b0);
    check("t4_dataout_after", dout, 1'b0);

    // Go held high: one IDLE cycle between frames
    rise_q.delete();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk); #1;
    send_pix(24'h123456, 24'h123456, 0, 1, f, a);
    send_pix(24'hABCDEF, 24'hABCDEF, 0, 1, f, a);
    wait_done(dc);
    check("t5_refetch_ready2go", r2g, 1'b0);
    check("t5_refetch_pix_ready", pif.pix_ready, 1'b1);
    go = 1'b0;
    rise_q.delete();
    send_pix(24'h800001, 24'h800001, 0, 1, f, a);
    send_pix(24'h7FFFFE, 24'h7FFFFE, 0, 1, f, a);
    wait_done(dc);
    check("t5_pulse_count", rise_q.size(), 48);
    check("t5_queue_empty", exp_q.size(), 0);

    // RGBW instance, 0x80000001
    w32 = 32'h80000001;
    @(negedge clk);
    check("t6_ready2go", r2g2, 1'b1);
    go2 = 1'b1;
    @(posedge clk); #1;
    go2 = 1'b0;
    pif2.pix_data = w32;
    pif2.pix_valid = 1'b1;
    @(posedge clk); #1;
    pif2.pix_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      hi = 0;
      repeat (10) begin
        if (dout2) hi++;
        @(negedge clk);
      end
      check($sformatf("t6_bit%0d_width", k), hi, w32[31-k] ? 7 : 3);
    end
    n = 0;
    hi = 0;
    while (!done2 && n < 200) begin
      if (dout2) hi++;
      @(negedge clk);
      n++;
    end
    check("t6_latch_len", n, 50);
    check("t6_latch_low", hi, 0);

`ifdef WS2812_BRIGHTNESS_EN
    // brightness 127 then 0 on a full-white pixel
    start_frame();
    bright = 8'd127;
    send_pix(24'hFF8040, 24'h7F4020, 0, 1, f, a);
    bright = 8'd0;
    send_pix(24'hFFFFFF, 24'h000000, 0, 1, f, a);
    wait_done(dc);
    check("t7_pulse_count", rise_q.size(), 48);
    check("t7_queue_empty", exp_q.size(), 0);
    bright = 8'd255;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ws2812_stream_sender.md
Name: ws2812_stream_sender

Overview:
Parametrised next-generation WS2812B/SK6812 frame sender. It takes a per-LED colour stream over a valid/ready handshake and serialises each word MSB-first as NZR waveforms. After the last LED it drives the latch/reset low time. It replaces the fixed-colour, fixed-count sender path and adds arbitrary LED count, RGBW mode, programmable timing and stall detection.

Parameters:
NUM_LEDS, 5, LEDs per frame (1..4095).
BITS_PER_LED, 24, 24 (GRB) or 32 (GRBW); other values are illegal.
T0H_CYC, 20, high time of a 0 bit, in clk cycles.
T1H_CYC, 40, high time of a 1 bit, in clk cycles.
BIT_CYC, 62, total bit period, in clk cycles. Constraint: 0 < T0H_CYC < T1H_CYC < BIT_CYC.
RESET_CYC, 15000, latch low time in cycles (300 us at 50 MHz; must exceed 280 us).
STALL_CYC, 1000, maximum low wait for an inter-LED pixel before the frame aborts.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Go  in  1  frame start request; sampled only in IDLE
pix_data  in  BITS_PER_LED  colour word, G byte in the MSBs
pix_valid  in  1  pix_data is valid
pix_ready  out  1  sender accepts pix_data this cycle
dataOut  out  1  serial line to the strip
Ready2Go  out  1  high in IDLE
done  out  1  one-cycle pulse when the latch time completes
underrun  out  1  sticky flag: last frame aborted by stall

Behaviour:
- Reset (async, reset=0): state IDLE. dataOut=0, Ready2Go=0 while reset is asserted, pix_ready=0, done=0, underrun=0. All counters are cleared. A reset mid-frame drops dataOut low immediately.
- The first clk edge after reset release sets Ready2Go=1 (IDLE).
- States: IDLE, FETCH, BIT, LATCH.
- IDLE: dataOut=0, Ready2Go=1. If Go=1 at an edge: go to FETCH, clear underrun, led_cnt=0. Ready2Go drops on that same edge.
- FETCH: pix_ready=1 (combinational from state), dataOut=0.
  - On an edge with pix_valid=1: load the shift register (after optional scaling), bit_cnt=BITS_PER_LED-1, cyc_cnt=0, go to BIT.
  - Waiting for the first LED of a frame has no timeout.
  - For later LEDs, stall_cnt increments each waiting cycle. If it reaches STALL_CYC: set underrun=1, go to LATCH. The partial frame is abandoned.
- BIT: dataOut=1 while cyc_cnt < (msb ? T1H_CYC : T0H_CYC), else 0.
  - cyc_cnt runs 0..BIT_CYC-1.
  - At cyc_cnt=BIT_CYC-1: if bit_cnt>0, shift left and decrement bit_cnt.
  - Otherwise increment led_cnt. If led_cnt==NUM_LEDS-1 go to LATCH, else go to FETCH with stall_cnt=0.
- Latency:
  - The pixel accepted at edge m gives dataOut=1 from cycle m+1.
  - If the next pixel is already valid, the inter-LED gap is exactly 1 extra low cycle (the FETCH cycle).
- LATCH: dataOut=0 for RESET_CYC cycles. Then done=1 for one cycle and go to IDLE (Ready2Go=1 on the same edge).
- Go is ignored outside IDLE.
- pix_valid is ignored outside FETCH; pix_ready=0 there.
- Go=1 held continuously: frames repeat back to back with exactly one IDLE cycle between them.
- Counter widths come from $clog2 of their maximum; none wrap within legal parameters.

Optional Feature:
Macro WS2812_BRIGHTNESS_EN.
- Defined: adds port brightness in 8 (sampled at pixel load). Each byte c of pix_data is replaced by (c*(brightness+1))>>8 before loading. brightness=255 is identity; 0 gives all-zero bits.
- Undefined: no brightness port; pix_data is loaded unmodified.

Test Plan:
Test parameters unless stated: NUM_LEDS=2, BITS_PER_LED=24, T0H=3, T1H=7, BIT_CYC=10, RESET_CYC=50, STALL_CYC=20.
- Reset: hold reset=0 mid-BIT -> dataOut=0 at once. After release, Ready2Go=1 and underrun=0.
- Timing: Go pulse, pixels 0xFF0000 then 0x00000F, always valid -> first 8 bits are 7-high/3-low; next 16+20 bits are 3-high/7-low except the last 4 bits (7-high). One low cycle between LEDs; done pulses exactly 50 cycles after the final bit ends.
- Handshake stall: withhold pix_valid for 10 cycles before LED 1 -> line low 10(+1) cycles, then LED 1 sends correctly, underrun=0.
- Underrun: withhold pix_valid for 25 cycles before LED 1 -> no more high pulses; LATCH low 50 cycles, done pulse, underrun=1. The next Go clears underrun.
- RGBW: BITS_PER_LED=32, NUM_LEDS=1, pixel 0x80000001 -> exactly 32 bit periods, first and last are 1-bits, the rest are 0-bits.
- Brightness (macro on): brightness=127, pixel 0xFF8040 -> bits sent equal 0x7F4020.
